mmio_timer: RTL

//  Memory-mapped timer peripheral. It is a responder on the MIPS data-memory bus
//  (we/a/wd/rd), the same bus that dmem answers. Software programs a prescaler,
//  a compare value and a control word by stores, and polls the counter and status by loads.
//  The top level routes rd from this block when hit=1 and from dmem otherwise.
//  It raises irq (drivable to an LED) on compare match.

---
 rtl/mmio_timer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mmio_timer.sv
// Memory-mapped timer peripheral on the MIPS data-memory bus.
// Eight-word register window at BASE: control, prescaler, counter, compare, status.
// The counter advances once per prescaled tick. A compare match sets a sticky
// status bit, and that bit can raise irq.
module mmio_timer #(
    parameter logic [31:0] BASE = 32'hFFFF_FF00,
    parameter int unsigned PSW  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        irq
);

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_COUNT    = 3'd2,
        REG_COMPARE  = 3'd3,
        REG_STATUS   = 3'd4
    } reg_sel_e;

    reg_sel_e          sel;
    logic              en;
    logic              auto_reload;
    logic              ie;
    logic              match;
    logic [PSW-1:0]    prescale;
    logic [PSW-1:0]    pcnt;
    logic [31:0]       count;
    logic [31:0]       compare;

    logic              wr;
    logic              wr_ctrl;
    logic              wr_prescale;
    logic              wr_count;
    logic              wr_compare;
    logic              wr_status;
    logic              tick;
    logic              tick_eff;
    logic              at_compare;
    logic              unused_addr_bits;

    assign hit = (a[31:5] == BASE[31:5]);
    assign sel = reg_sel_e'(a[4:2]);
    assign wr  = we && hit;

    // Word-aligned bus: the byte-lane bits carry no information here.
    assign unused_addr_bits = ^a[1:0];

    assign wr_ctrl     = wr && (sel == REG_CTRL);
    assign wr_prescale = wr && (sel == REG_PRESCALE);
    assign wr_count    = wr && (sel == REG_COUNT);
    assign wr_compare  = wr && (sel == REG_COMPARE);
    assign wr_status   = wr && (sel == REG_STATUS);

    // A CPU store to COUNT or CTRL overrides a tick that lands in the same cycle.
    assign tick       = en && (pcnt == prescale);
    assign tick_eff   = tick && !wr_count && !wr_ctrl;
    assign at_compare = (count == compare);

    assign irq = match && ie;

    // Combinational read mux. Unmapped offsets and misses return 0.
    always_comb begin
        rd = '0;
        if (hit) begin
            case (sel)
                REG_CTRL:     rd = {29'd0, ie, auto_reload, en};
                REG_PRESCALE: rd = 32'(prescale);
                REG_COUNT:    rd = count;
                REG_COMPARE:  rd = compare;
                REG_STATUS:   rd = {31'd0, match};
                default:      rd = '0;
            endcase
        end
    end

    // Prescaler: free-runs while enabled and restarts on any CTRL/PRESCALE store.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pcnt <= '0;
        else if (wr_ctrl || wr_prescale || !en || tick)
            pcnt <= '0;
        else
            pcnt <= pcnt + PSW'(1);
    end

    // Control word. A one-shot match clears EN unless a CTRL store takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            ie          <= 1'b0;
        end else if (wr_ctrl) begin
            en          <= wd[0];
            auto_reload <= wd[1];
            ie          <= wd[2];
        end else if (tick_eff && at_compare && !auto_reload) begin
            en <= 1'b0;
        end
    end

    // Prescale and compare registers are written only by the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
            compare  <= '0;
        end else begin
            if (wr_prescale) prescale <= wd[PSW-1:0];
            if (wr_compare)  compare  <= wd;
        end
    end

    // Counter: a CPU store wins. On a match tick the counter reloads to 0 in auto
    // mode or holds in one-shot mode. Otherwise it increments and wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (wr_count)
            count <= wd;
        else if (tick_eff) begin
            if (!at_compare)
                count <= count + 32'd1;
            else if (auto_reload)
                count <= '0;
        end
    end

    // Sticky MATCH flag. A match set beats a write-1-to-clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            match <= 1'b0;
        else if (tick_eff && at_compare)
            match <= 1'b1;
        else if (wr_status && wd[0])
            match <= 1'b0;
    end

endmodule
